// File: rtl/adc_rand_source.sv
// Synthetic ADC sample source: constant / ramp / PN16 / alternating samples at a programmable
// rate, with optional LSB-keyed randomizer encoding. Define ADC_SRC_OVR_EN to build the overrange flag.
module adc_rand_source #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clka,
  input  logic        local_reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic        rand_en,
  input  logic [15:0] const_i,
  input  logic [15:0] step_i,
  input  logic [7:0]  rate_div,
  output logic [15:0] ADC_o,
  output logic        ADC_rand_o,
  output logic        ADC_valid_o,
  output logic        ADC_ovr_o,
  output logic [31:0] sample_cnt_o
);

  // An all-zero seed would lock the LFSR, so substitute 1.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [7:0]  div_cnt;
  logic [15:0] acc;
  logic [15:0] lfsr;
  logic        toggle;
  logic [15:0] raw;
  logic [15:0] lfsr_nxt;
  logic        sample_edge;

  assign lfsr_nxt    = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign sample_edge = (state == RUN) && enable && (div_cnt == rate_div);

  always_comb begin
    raw = const_i;
    case (mode)
      2'd1:    raw = acc;
      2'd2:    raw = lfsr;
      2'd3:    raw = toggle ? (16'd0 - const_i) : const_i;
      default: raw = const_i;
    endcase
  end

  always_ff @(posedge clka or negedge local_reset_n) begin
    if (!local_reset_n) begin
      state        <= IDLE;
      div_cnt      <= 8'd0;
      acc          <= 16'd0;
      lfsr         <= SEED;
      toggle       <= 1'b0;
      ADC_o        <= 16'd0;
      ADC_rand_o   <= 1'b0;
      ADC_valid_o  <= 1'b0;
      sample_cnt_o <= 32'd0;
    end else begin
      ADC_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state        <= RUN;
            div_cnt      <= 8'd0;
            acc          <= 16'd0;
            lfsr         <= SEED;
            toggle       <= 1'b0;
            sample_cnt_o <= 32'd0;
          end
        end
        RUN: begin
          if (!enable) begin
            state <= IDLE;
          end else if (sample_edge) begin
            div_cnt      <= 8'd0;
            ADC_o        <= (rand_en && raw[0]) ? (raw ^ 16'hFFFE) : raw;
            ADC_rand_o   <= rand_en;
            ADC_valid_o  <= 1'b1;
            sample_cnt_o <= sample_cnt_o + 32'd1;
            // Only the selected generator advances; the others keep their state.
            case (mode)
              2'd1:    acc    <= acc + step_i;
              2'd2:    lfsr   <= lfsr_nxt;
              2'd3:    toggle <= ~toggle;
              default: ;
            endcase
          end else begin
            // Free-running 8-bit wrap covers a rate_div lowered below the current count.
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADC_SRC_OVR_EN
  always_ff @(posedge clka or negedge local_reset_n) begin
    if (!local_reset_n)
      ADC_ovr_o <= 1'b0;
    else if (sample_edge)
      ADC_ovr_o <= (raw == 16'h7FFF) || (raw == 16'h8000);
  end
`else
  assign ADC_ovr_o = 1'b0;
`endif

endmodule
